// File: rtl/rf_shot_sequencer.sv
// Multi-channel laser shot sequencer.
// A single time base t drives every per-channel strobe window, and the block
// measures the synchronised comparator echo time once per shot. Shots run
// either as a burst of cfg_shots shots or continuously when cfg_shots is 0.
//
// Control handshake: start and abort are plain level inputs that are sampled
// on every rising clock edge. There is no ready signal. A start seen in IDLE
// (with abort low) launches a run. Start is ignored while a run is active.
// Abort forces the block back to IDLE on the next edge and takes priority
// over everything else.
module rf_shot_sequencer #(
    parameter int CNT_WIDTH   = 16,
    parameter int NUM_CH      = 3,
    parameter int SHOTS_WIDTH = 8,
    parameter int FIRE_CH     = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH*CNT_WIDTH-1:0] cfg_delay,
    input  logic [NUM_CH*CNT_WIDTH-1:0] cfg_width,
    input  logic [CNT_WIDTH-1:0]        cfg_period,
    input  logic [SHOTS_WIDTH-1:0]      cfg_shots,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        comparator,
    output logic [NUM_CH-1:0]           ch_out,
    output logic                        busy,
    output logic                        shot_done,
    output logic [SHOTS_WIDTH-1:0]      shot_count,
    output logic                        echo_valid,
    output logic [CNT_WIDTH-1:0]        echo_time,
    output logic                        echo_timeout
);

    localparam logic [CNT_WIDTH-1:0]   T_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHOTS_WIDTH-1:0] S_ONE = {{(SHOTS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    // Shadow copies of the configuration, frozen for the duration of a run.
    logic [NUM_CH*CNT_WIDTH-1:0] delay_sh;
    logic [NUM_CH*CNT_WIDTH-1:0] width_sh;
    logic [CNT_WIDTH-1:0]        period_sh;   // already forced to at least 1
    logic [SHOTS_WIDTH-1:0]      shots_sh;

    logic [CNT_WIDTH-1:0]        t;
    logic [NUM_CH-1:0]           win_vec;
    logic                        captured;
    logic                        fire_seen;
    logic [2:0]                  sync_q;
    logic                        echo_rise;
    logic                        echo_hit;
    logic                        shot_last;
    logic                        burst_last;
    logic [SHOTS_WIDTH-1:0]      count_inc;

    logic do_start, do_abort, do_end, do_finish;

    assign busy = (state == ST_RUN);

    // Per-channel window test on the current time base value. The upper
    // bound is formed one bit wider so delay+width can never wrap.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_win
        logic [CNT_WIDTH:0] lo;
        logic [CNT_WIDTH:0] hi;
        assign lo = {1'b0, delay_sh[i*CNT_WIDTH +: CNT_WIDTH]};
        assign hi = {1'b0, delay_sh[i*CNT_WIDTH +: CNT_WIDTH]}
                  + {1'b0, width_sh[i*CNT_WIDTH +: CNT_WIDTH]};
        assign win_vec[i] = ({1'b0, t} >= lo) && ({1'b0, t} < hi);
    end

    assign shot_last  = (t == (period_sh - T_ONE));
    assign count_inc  = shot_count + S_ONE;
    assign burst_last = (shots_sh != '0) && (count_inc == shots_sh);

    // sync_q[1] is the synchronised comparator and sync_q[2] its previous
    // value, so a rising echo is visible one cycle after synchronisation.
    assign echo_rise = sync_q[1] & ~sync_q[2];

    // The echo window is open from the first cycle the fire strobe is high
    // in this shot until the end of the shot. Only the first edge counts.
    assign echo_hit  = (state == ST_RUN) && echo_rise && !captured
                     && (ch_out[FIRE_CH] || fire_seen);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and run-control decode. Abort outranks end of shot.
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_abort   = 1'b0;
        do_end     = 1'b0;
        do_finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_RUN;
                    do_start   = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    do_abort   = 1'b1;
                end else if (shot_last) begin
                    do_end = 1'b1;
                    if (burst_last) begin
                        state_next = ST_IDLE;
                        do_finish  = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Two-flop synchroniser for the asynchronous comparator plus an edge-history flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], comparator};
        end
    end

    // Time base, strobes, shot accounting and echo capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_sh     <= '0;
            width_sh     <= '0;
            period_sh    <= '0;
            shots_sh     <= '0;
            t            <= '0;
            ch_out       <= '0;
            shot_done    <= 1'b0;
            shot_count   <= '0;
            echo_valid   <= 1'b0;
            echo_time    <= '0;
            echo_timeout <= 1'b0;
            captured     <= 1'b0;
            fire_seen    <= 1'b0;
        end else begin
            shot_done    <= 1'b0;
            echo_valid   <= 1'b0;
            echo_timeout <= 1'b0;
            if (do_start) begin
                delay_sh   <= cfg_delay;
                width_sh   <= cfg_width;
                period_sh  <= (cfg_period == '0) ? T_ONE : cfg_period;
                shots_sh   <= cfg_shots;
                t          <= '0;
                shot_count <= '0;
                ch_out     <= '0;
                captured   <= 1'b0;
                fire_seen  <= 1'b0;
            end else if (do_abort) begin
                t         <= '0;
                ch_out    <= '0;
                captured  <= 1'b0;
                fire_seen <= 1'b0;
            end else if (state == ST_RUN) begin
                ch_out <= do_finish ? '0 : win_vec;
                if (echo_hit) begin
                    echo_valid <= 1'b1;
                    echo_time  <= t;
                end
                if (do_end) begin
                    t            <= '0;
                    shot_done    <= 1'b1;
                    shot_count   <= count_inc;
                    echo_timeout <= !(captured || echo_hit);
                    captured     <= 1'b0;
                    fire_seen    <= 1'b0;
                end else begin
                    t <= t + T_ONE;
                    if (echo_hit) begin
                        captured <= 1'b1;
                    end
                    if (ch_out[FIRE_CH]) begin
                        fire_seen <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_shot_sequencer.sv
// Self-checking bench for rf_shot_sequencer: shot-level reference model,
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_rf_shot_sequencer;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int SW = 8;
    localparam int F  = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*W-1:0] cfg_delay = '0;
    logic [N*W-1:0] cfg_width = '0;
    logic [W-1:0]   cfg_period = '0;
    logic [SW-1:0]  cfg_shots = '0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           comparator = 1'b0;

    logic [N-1:0]   ch_out;
    logic           busy;
    logic           shot_done;
    logic [SW-1:0]  shot_count;
    logic           echo_valid;
    logic [W-1:0]   echo_time;
    logic           echo_timeout;

    rf_shot_sequencer #(
        .CNT_WIDTH(W), .NUM_CH(N), .SHOTS_WIDTH(SW), .FIRE_CH(F)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_period(cfg_period), .cfg_shots(cfg_shots),
        .start(start), .abort(abort), .comparator(comparator),
        .ch_out(ch_out), .busy(busy), .shot_done(shot_done),
        .shot_count(shot_count), .echo_valid(echo_valid),
        .echo_time(echo_time), .echo_timeout(echo_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time within a shot is the number of edges since launch modulo the
    // period; a strobe seen after an edge reflects the window test of the
    // time value that held just before that edge.
    logic          m_run = 1'b0;
    int            m_n = 0;
    int            m_p = 1;
    int            m_d[N];
    int            m_w[N];
    int            m_shots = 0;
    logic [SW-1:0] m_count = '0;
    logic          m_cap = 1'b0;
    logic          m_fire_seen = 1'b0;
    logic          h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    logic [N-1:0]  exp_ch = '0;
    logic          exp_done = 1'b0, exp_ev = 1'b0, exp_to = 1'b0;
    logic [W-1:0]  exp_et = '0;

    always @(posedge clk or negedge reset_n) begin
        int  tt;
        logic rise;
        if (!reset_n) begin
            m_run = 1'b0; m_n = 0; m_count = '0; m_cap = 1'b0; m_fire_seen = 1'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            exp_ch = '0; exp_done = 1'b0; exp_ev = 1'b0; exp_to = 1'b0; exp_et = '0;
        end else begin
            rise = h2 & ~h3;
            exp_done = 1'b0; exp_ev = 1'b0; exp_to = 1'b0;
            if (!m_run) begin
                if (start && !abort) begin
                    for (int i = 0; i < N; i++) begin
                        m_d[i] = int'(cfg_delay[i*W +: W]);
                        m_w[i] = int'(cfg_width[i*W +: W]);
                    end
                    m_p = (cfg_period == 0) ? 1 : int'(cfg_period);
                    m_shots = int'(cfg_shots);
                    m_run = 1'b1; m_n = 0; m_count = '0;
                    m_cap = 1'b0; m_fire_seen = 1'b0;
                end
            end else if (abort) begin
                m_run = 1'b0; exp_ch = '0;
            end else begin
                tt = m_n % m_p;
                if (rise && !m_cap && (exp_ch[F] || m_fire_seen)) begin
                    exp_ev = 1'b1; exp_et = W'(tt); m_cap = 1'b1;
                end
                if (exp_ch[F]) m_fire_seen = 1'b1;
                for (int i = 0; i < N; i++)
                    exp_ch[i] = (tt >= m_d[i]) && (tt < m_d[i] + m_w[i]);
                m_n++;
                if (tt == m_p - 1) begin
                    exp_done = 1'b1;
                    m_count  = m_count + 1'b1;
                    exp_to   = !m_cap;
                    m_cap = 1'b0; m_fire_seen = 1'b0;
                    if (m_shots != 0 && int'(m_count) == m_shots) begin
                        m_run = 1'b0; exp_ch = '0;
                    end
                end
            end
            h3 = h2; h2 = h1; h1 = comparator;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("ch_out",       32'(ch_out),       32'(exp_ch));
            check("busy",         32'(busy),         32'(m_run));
            check("shot_done",    32'(shot_done),    32'(exp_done));
            check("shot_count",   32'(shot_count),   32'(m_count));
            check("echo_valid",   32'(echo_valid),   32'(exp_ev));
            check("echo_time",    32'(echo_time),    32'(exp_et));
            check("echo_timeout", 32'(echo_timeout), 32'(exp_to));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int i, input int d, input int w);
        cfg_delay[i*W +: W] = W'(d);
        cfg_width[i*W +: W] = W'(w);
    endtask

    // Raise start for one edge (E0); returns at the negedge after E0.
    task automatic launch();
        start = 1'b1;
        go(1);
        start = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        go(3);
        check("reset_ch_out", 32'(ch_out), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_count", 32'(shot_count), 0);
        #2 reset_n = 1'b1;
        check_en = 1'b1;
        go(2);

        // Basic burst with echo, early ignored edge and second-shot timeout.
        cfg_period = 100; cfg_shots = 2;
        set_ch(0, 0, 10); set_ch(1, 20, 5); set_ch(2, 20, 1);
        launch();
        go(1);  check("burst_e1_ch", 32'(ch_out), 32'b001);
        go(4);  comparator = 1'b1;
        go(5);  comparator = 1'b0;
        go(11); check("burst_e21_ch", 32'(ch_out), 32'b110);
        go(29); comparator = 1'b1;
        go(3);  check("echo_valid_52", 32'(echo_valid), 1);
                check("echo_time_52", 32'(echo_time), 52);
        go(7);  comparator = 1'b0;
        go(40); check("shot1_done", 32'(shot_done), 1);
                check("shot1_count", 32'(shot_count), 1);
                check("shot1_no_timeout", 32'(echo_timeout), 0);
        go(100); check("shot2_count", 32'(shot_count), 2);
                 check("shot2_timeout", 32'(echo_timeout), 1);
                 check("burst_end_busy", 32'(busy), 0);
        go(3);

        // Truncation and zero width.
        cfg_period = 30; cfg_shots = 2;
        set_ch(0, 0, 0); set_ch(1, 25, 20); set_ch(2, 0, 0);
        launch();
        go(25); check("trunc_e25_ch", 32'(ch_out), 32'b000);
        go(1);  check("trunc_e26_ch", 32'(ch_out), 32'b010);
        go(4);  check("trunc_e30_ch", 32'(ch_out), 32'b010);
                check("trunc_e30_done", 32'(shot_done), 1);
        go(1);  check("trunc_e31_ch", 32'(ch_out), 32'b000);
        go(29); check("trunc_end_busy", 32'(busy), 0);
                check("trunc_end_count", 32'(shot_count), 2);
        go(2);

        // Zero period behaves as one clock per shot.
        cfg_period = 0; cfg_shots = 3;
        launch();
        go(1); check("p0_e1_done", 32'(shot_done), 1);
               check("p0_e1_count", 32'(shot_count), 1);
        go(1); check("p0_e2_done", 32'(shot_done), 1);
        go(1); check("p0_e3_count", 32'(shot_count), 3);
               check("p0_e3_busy", 32'(busy), 0);
        go(2);

        // Continuous run: cfg change and start ignored, abort in shot 3.
        cfg_period = 50; cfg_shots = 0;
        set_ch(0, 0, 10); set_ch(1, 20, 5); set_ch(2, 20, 1);
        launch();
        go(10); set_ch(0, 5, 10); set_ch(1, 5, 5); set_ch(2, 5, 1);
        go(50); start = 1'b1;
        go(2);  start = 1'b0;
        go(68); abort = 1'b1;
        go(1);  abort = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_ch", 32'(ch_out), 0);
                check("abort_count", 32'(shot_count), 2);
                check("abort_no_done", 32'(shot_done), 0);
        go(3);
        set_ch(0, 0, 10); set_ch(1, 20, 5); set_ch(2, 20, 1);

        // Echo landing on the last cycle of the shot.
        cfg_period = 20; cfg_shots = 1;
        set_ch(0, 0, 0); set_ch(1, 2, 3); set_ch(2, 0, 0);
        launch();
        go(17); comparator = 1'b1;
        go(3);  check("last_echo_valid", 32'(echo_valid), 1);
                check("last_echo_time", 32'(echo_time), 19);
                check("last_no_timeout", 32'(echo_timeout), 0);
                check("last_done", 32'(shot_done), 1);
        comparator = 1'b0;
        go(3);

        // Start together with abort in IDLE.
        start = 1'b1; abort = 1'b1;
        go(3);  check("start_abort_idle", 32'(busy), 0);
        start = 1'b0; abort = 1'b0;
        go(2);

        // Asynchronous reset in the middle of a continuous run.
        cfg_shots = 0;
        launch();
        go(10);
        #2 reset_n = 1'b0;
        #1 check("rst_ch_out", 32'(ch_out), 0);
           check("rst_busy", 32'(busy), 0);
           check("rst_echo_time", 32'(echo_time), 0);
           check("rst_count", 32'(shot_count), 0);
        go(5);
        #2 reset_n = 1'b1;
        go(10); check("rst_no_restart", 32'(busy), 0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_shot_sequencer.md
Name: rf_shot_sequencer

Overview:
- Parametrised multi-channel laser shot sequencer.
- Successor to the separate single-pulse laser charge / laser enable / TDC start generators. One block produces all timed strobes per shot from a common time base.
- Supports burst and continuous shot trains, and measures the comparator echo time per shot.
- Sits between the CPU register interface and the laser/TDC pins, clocked by the 200 MHz reference clock.

Parameters:
CNT_WIDTH, 16, width of shot time base, delays, widths, period and echo time
NUM_CH, 3, number of timed output channels (0 = charge, 1 = fire, 2 = TDC start by convention)
SHOTS_WIDTH, 8, width of shot count configuration and counter
FIRE_CH, 1, channel index whose rising edge opens the echo window

Ports:
clk  in  1  sequencer clock (200 MHz reference clock)
reset_n  in  1  asynchronous active-low reset
cfg_delay  in  NUM_CH*CNT_WIDTH  per-channel start offset in clocks; channel i at bits [i*CNT_WIDTH +: CNT_WIDTH]
cfg_width  in  NUM_CH*CNT_WIDTH  per-channel pulse width in clocks
cfg_period  in  CNT_WIDTH  shot period in clocks
cfg_shots  in  SHOTS_WIDTH  shots per burst; 0 = continuous
start  in  1  start request, level sampled
abort  in  1  stop request, level sampled
comparator  in  1  asynchronous echo comparator output
ch_out  out  NUM_CH  timed strobes, registered
busy  out  1  high while in RUN
shot_done  out  1  one-cycle pulse at end of each completed shot
shot_count  out  SHOTS_WIDTH  completed shots since last start
echo_valid  out  1  one-cycle pulse when echo is captured
echo_time  out  CNT_WIDTH  time base value at echo detection
echo_timeout  out  1  one-cycle pulse at end of a shot with no echo

Behaviour:
- Reset: state IDLE, all outputs 0, time base t=0, all shadow registers 0, synchroniser flops 0.
- States:
  - IDLE: waiting for start.
  - RUN: shots in progress.
- IDLE with start=1 and abort=0 sampled on edge E0:
  - Latch all cfg_* into shadow registers; cfg changes during RUN have no effect.
  - t=0, shot_count=0, busy=1, enter RUN.
- start while in RUN is ignored.
- Period: effective period P = max(cfg_period, 1).
- Time base: in RUN, t increments each clock; at t=P-1 it wraps to 0 (end of shot).
- Channel windows:
  - ch_out[i] is registered from t: it is 1 on the clock after t satisfies delay_i <= t < delay_i + width_i.
  - The sum is computed at CNT_WIDTH+1 bits, with no wrap.
  - Result: first shot rises on edge E(delay_i+1) and is high for width_i cycles.
  - Windows are truncated at t=P-1; they never straddle shots.
  - width_i=0 or delay_i>=P means the channel is never asserted.
- Echo path:
  - comparator passes through a 2-flop synchroniser, then rising-edge detect.
  - The echo window opens on the cycle ch_out[FIRE_CH] first rises within the current shot and closes at end of shot.
  - On the first detected rising edge in an open window: echo_time <= t, echo_valid pulses for 1 cycle.
  - Further edges in the same shot are ignored.
  - The synchroniser latency (2 clocks) is not compensated; software subtracts it.
  - Edges outside the window are ignored.
- End of shot (t=P-1, no abort):
  - shot_done pulses for 1 cycle.
  - shot_count increments; in continuous mode it wraps at 2^SHOTS_WIDTH.
  - echo_timeout pulses in the same cycle if no echo was captured in that shot.
  - Echo capture state clears.
- Burst end: if cfg_shots != 0 and the incremented count equals cfg_shots, go to IDLE, busy=0, ch_out=0. shot_count holds its final value.
- Simultaneous events:
  - Echo edge on the final cycle t=P-1 is captured (echo_valid) and suppresses echo_timeout.
  - abort has priority over end of shot and echo.
- Abort: abort=1 in RUN → at the next edge go to IDLE, ch_out=0, busy=0. No shot_done and no echo_timeout for the partial shot; shot_count holds.
- Simultaneous start and abort in IDLE: remain in IDLE.
- Reset mid-operation: immediate return to the reset state, asynchronously.
- echo_time holds its last captured value until the next capture.

Test Plan:
- Reset check: reset_n low for 5 cycles mid-RUN → all outputs 0 immediately, no restart after release until start.
- Basic burst: P=100, shots=2, ch0 delay 0/width 10, ch1 delay 20/width 5, ch2 delay 20/width 1, start at E0:
  - ch0 high on E1..E10.
  - ch1 high on E21..E25.
  - ch2 high on E21 only.
  - Channels repeat 100 clocks later.
  - shot_done pulses twice, shot_count=2, then busy=0.
- Echo and timeout: same config, comparator rising at t=50 in shot 1, none in shot 2:
  - Shot 1: echo_valid with echo_time=52.
  - Shot 2: echo_timeout pulse at end.
  - An early comparator edge at t=5 (before FIRE) is ignored.
- Truncation and zero config: P=30, ch1 delay 25/width 20; ch0 width 0; cfg_period=0 in a later run:
  - ch1 high only for t=25..29.
  - ch0 never asserts.
  - With cfg_period=0, shot_done fires every cycle.
- Abort and shadowing: continuous mode P=50, change cfg_delay mid-run (no effect), abort at t=30 of shot 3:
  - IDLE next edge, ch_out=0.
  - shot_count=2, no shot_done.
  - start during RUN is ignored.
- Simultaneous events:
  - Echo edge landing on t=P-1 → echo_valid=1 and echo_timeout=0 in the same cycle.
  - start and abort both high in IDLE → stays IDLE.
